// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter
// Shares the single data-memory port between the pipeline M-stage (port 0)
// and the loader/debug port (port 1). Requests are arbitrated round-robin.
// Each winning request runs as one memory transaction with a req/ack
// handshake. Every transaction is bounded by a timeout, and every
// transaction ends in exactly one response pulse.

module dmem_access_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           iClk,
  input  logic                           iRstN,
  input  logic [1:0]                     iReqValid,
  input  logic [1:0]                     iReqWrite,
  input  logic [1:0][ADDR_WIDTH-1:0]     iReqAddr,
  input  logic [1:0][DATA_WIDTH-1:0]     iReqWData,
  input  logic [1:0][DATA_WIDTH/8-1:0]   iReqByteEn,
  output logic [1:0]                     oReqReady,
  output logic [1:0]                     oRspValid,
  output logic [DATA_WIDTH-1:0]          oRspData,
  output logic                           oRspErr,
  output logic                           oMemReq,
  output logic                           oMemWrite,
  output logic [ADDR_WIDTH-1:0]          oMemAddr,
  output logic [DATA_WIDTH-1:0]          oMemWData,
  output logic [DATA_WIDTH/8-1:0]        oMemByteEn,
  input  logic                           iMemAck,
  input  logic [DATA_WIDTH-1:0]          iMemRData,
  output logic                           oSpuriousAck
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  // Clears the two byte-offset bits, so the memory always sees a word address.
  localparam logic [ADDR_WIDTH-1:0] ADDR_WORD_MASK = ~(ADDR_WIDTH'(3));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    last_grant;
  logic                    cur_port;
  logic [CNT_WIDTH-1:0]    tmo_cnt;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_err;
  logic                    spurious;

  logic                    grant_port;
  logic                    grant_noop;
  logic                    grant_en;
  logic                    issue_ack;
  logic                    issue_tmo;
  logic [1:0]              req_ready;
  logic [1:0]              rsp_valid;

  // On a tie, the port that did not win last time goes first.
  // Otherwise, the only valid port is the winner.
  assign grant_port = (&iReqValid) ? ~last_grant : iReqValid[1];
  // A request with no byte lanes enabled touches no memory.
  // It is answered with an error.
  assign grant_noop = (iReqByteEn[grant_port] == '0);

  // State register
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the per-state handshake strobes
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    issue_ack = 1'b0;
    issue_tmo = 1'b0;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state)
      ST_IDLE: begin
        if (|iReqValid) begin
          grant_en              = 1'b1;
          req_ready[grant_port] = 1'b1;
          state_nxt             = grant_noop ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (iMemAck) begin
          issue_ack = 1'b1;
          state_nxt = ST_RESP;
        end else if (tmo_cnt == CNT_LAST) begin
          issue_tmo = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid[cur_port] = 1'b1;
        state_nxt           = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Memory-side registers
  // These are loaded at the grant, held through ISSUE, and cleared when
  // the transaction leaves ISSUE.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oMemReq    <= 1'b0;
      oMemWrite  <= 1'b0;
      oMemAddr   <= '0;
      oMemWData  <= '0;
      oMemByteEn <= '0;
    end else if (grant_en && !grant_noop) begin
      oMemReq    <= 1'b1;
      oMemWrite  <= iReqWrite[grant_port];
      oMemAddr   <= iReqAddr[grant_port] & ADDR_WORD_MASK;
      oMemWData  <= iReqWData[grant_port];
      oMemByteEn <= iReqByteEn[grant_port];
    end else if (issue_ack || issue_tmo) begin
      oMemReq    <= 1'b0;
      oMemWrite  <= 1'b0;
      oMemAddr   <= '0;
      oMemWData  <= '0;
      oMemByteEn <= '0;
    end
  end

  // Timeout counter
  // It is cleared at each grant and counts the cycles spent in ISSUE.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      tmo_cnt <= '0;
    end else if (grant_en) begin
      tmo_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Response payload and the owner of the current transaction
  // Writes and failed transactions return a zero word.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cur_port <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (grant_en) begin
      cur_port <= grant_port;
      rsp_data <= '0;
      rsp_err  <= grant_noop;
    end else if (issue_ack) begin
      rsp_data <= oMemWrite ? '0 : iMemRData;
      rsp_err  <= 1'b0;
    end else if (issue_tmo) begin
      rsp_data <= '0;
      rsp_err  <= 1'b1;
    end
  end

  // Round-robin history
  // The port just answered loses the next tie. Reset favours port 0.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      last_grant <= 1'b1;
    end else if (state == ST_RESP) begin
      last_grant <= cur_port;
    end
  end

  // Sticky flag for a memory ack that arrives while no access is in flight
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      spurious <= 1'b0;
    end else if (iMemAck && (state != ST_ISSUE)) begin
      spurious <= 1'b1;
    end
  end

  // The accept pulse is decoded from IDLE.
  // It is also forced low while reset is held, so every output is quiet
  // during reset.
  assign oReqReady    = iRstN ? req_ready : 2'b00;
  assign oRspValid    = rsp_valid;
  assign oRspData     = (state == ST_RESP) ? rsp_data : '0;
  assign oRspErr      = (state == ST_RESP) && rsp_err;
  assign oSpuriousAck = spurious;

endmodule
